// File: rtl/rgb555_pixel_assembler.sv
// RGB555 pixel assembler: rebuilds 15-bit pixels from a high-byte-first
// byte stream and frames them with start/done/error strobes.
module rgb555_pixel_assembler #(
    parameter int MAX_PIXEL_BITS = 15,
    parameter int FRAME_PIXELS   = 76800,
    parameter int CNT_W          = 17
) (
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic                      sof_i,
    input  logic                      byte_valid_i,
    input  logic [7:0]                byte_i,
    output logic [MAX_PIXEL_BITS-1:0] px_rgb_o,
    output logic                      px_valid_o,
    output logic                      start_o,
    output logic                      frame_done_o,
    output logic                      frame_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_PX = CNT_W'(FRAME_PIXELS - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [6:0]                hi_q, hi_d;
    logic [MAX_PIXEL_BITS-1:0] px_d;
    logic                      valid_d;
    logic                      start_d;
    logic                      done_d;
    logic                      err_d;

    // Next-state and next-output decode; sof has priority over bytes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        px_d    = px_rgb_o;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sof_i) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                    hi_d    = '0;
                end
            end
            WAIT_HI: begin
                if (sof_i) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                    hi_d    = '0;
                    err_d   = 1'b1;
                end else if (byte_valid_i) begin
                    hi_d    = byte_i[6:0];
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (sof_i) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                    hi_d    = '0;
                    err_d   = 1'b1;
                end else if (byte_valid_i) begin
                    px_d    = MAX_PIXEL_BITS'({hi_q, byte_i});
                    valid_d = 1'b1;
                    if (cnt_q == LAST_PX) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = WAIT_HI;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d != IDLE);
    end

    // State and registered outputs, cleared asynchronously on reset
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            px_rgb_o     <= '0;
            px_valid_o   <= 1'b0;
            start_o      <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            px_rgb_o     <= px_d;
            px_valid_o   <= valid_d;
            start_o      <= start_d;
            frame_done_o <= done_d;
            frame_err_o  <= err_d;
        end
    end

endmodule
